sum_accum: RTL and testbench
============================

SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 Parameter W, default 8: width of each input lane.
REQ-002 Parameter N, default 4: number of input lanes; SHALL be even and >= 2.
REQ-003 Parameter AW, default 12: result/accumulator width; SHALL be >= W+clog2(N)+1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 ins  input  N*W  packed lanes, lane k at bits [(k+1)*W-1 : k*W], unsigned.
REQ-009 cin  input  1  carry-in added to beat, qualified by in_valid.
REQ-010 mode  input  1  0 = plain sum, 1 = accumulate; qualified by in_valid.
REQ-011 acc_clr  input  1  clear accumulator before applying this beat; qualified by in_valid.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 sm  output  AW  result.
REQ-015 sm_zero  output  1  sm == 0.
REQ-016 sm_ovf  output  1  true sum of this beat exceeded 2^AW-1.

Function
REQ-017 Beat accepted when in_valid && in_ready; result delivered when out_valid && out_ready.
REQ-018 Two register stages: S1 holds two half-sums (lanes 0..N/2-1, lanes N/2..N-1) plus cin, mode, acc_clr; S2 is the output register.
REQ-019 Latency SHALL be exactly 2 cycles from acceptance to out_valid when unstalled; throughput 1 beat/cycle.
REQ-020 S2 loads when S1 valid and (!out_valid || out_ready); S1 loads when in_valid and (S1 empty or S1 moving to S2).
REQ-021 in_ready = !S1_valid || S1 moves this cycle; no combinational path from in_valid to in_ready.
REQ-022 Mode 0: sm = half0 + half1 + cin, zero-extended to AW; accumulator untouched unless acc_clr.
REQ-023 Mode 1: base = acc_clr ? 0 : acc; sm = base + half0 + half1 + cin modulo 2^AW; acc <= sm on S2 load.
REQ-024 acc_clr with mode 0: acc <= 0 on S2 load; sm unaffected by clear.
REQ-025 Back-to-back mode-1 beats SHALL chain: each beat sees acc including all previous beats (acc updated in same cycle as S2 load).
REQ-026 sm_ovf = carry out of bit AW-1 for that beat; not sticky; sm wraps.
REQ-027 sm, sm_zero, sm_ovf held stable while out_valid && !out_ready.
REQ-028 No beat lost or duplicated under any out_ready pattern; order preserved.

Reset
REQ-029 On rst: S1_valid=0, out_valid=0, sm=0, sm_zero=0, sm_ovf=0, acc=0; in_ready=1 the cycle after rst deasserts.
REQ-030 rst mid-operation SHALL discard all in-flight beats; inputs ignored while rst high.

Structure
REQ-031 Shared package sum_accum_pkg SHALL hold mode encoding constants (MODE_SUM=0, MODE_ACC=1) and the clog2-based minimum-AW function.
REQ-032 One sub-module, lane_sum: combinational parameterised adder of N/2 W-bit lanes, instantiated twice for the S1 half-sums.

Verification (W=8, N=4, AW=12)
REQ-033 ins={4,3,2,1}, cin=1, mode=0 -> sm=11, sm_zero=0, sm_ovf=0, out_valid exactly 2 cycles after accept.
REQ-034 ins all 255, cin=1 -> sm=1021, sm_ovf=0; ins all 0, cin=0 -> sm=0, sm_zero=1.
REQ-035 mode=1, first beat acc_clr=1, 4 consecutive beats lanes all 10, cin=0 -> sm=40,80,120,160 on consecutive cycles.
REQ-036 acc=4000, mode=1 beat lanes all 255, cin=0 -> sm=924, sm_ovf=1; next beat lanes all 0 -> sm=924, sm_ovf=0.
REQ-037 out_ready=0 for 5 cycles with in_valid held, 4-beat stream -> in_ready drops after 2 beats accepted; after release all 4 results delivered in order, none lost.
REQ-038 rst asserted 1 cycle while 2 beats in flight -> out_valid=0 and acc=0 next cycle; no stale result emerges afterwards.

Source files
------------

// File: rtl/sum_accum_pkg.sv
// Shared definitions for the sum_accum block: beat mode encoding and
// the minimum result width needed to hold a full beat sum without wrap.
package sum_accum_pkg;

    typedef enum logic {
        MODE_SUM = 1'b0,
        MODE_ACC = 1'b1
    } mode_e;

    function automatic int unsigned min_aw(input int unsigned w, input int unsigned n);
        return w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/sum_accum_if.sv
// Beat/result handshake bundle for sum_accum; the slave modport is the block
// side, the master modport is the upstream/downstream side.
interface sum_accum_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 4,
    parameter int unsigned AW = 12
);
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] ins;
    logic           cin;
    logic           mode;
    logic           acc_clr;
    logic           out_valid;
    logic           out_ready;
    logic [AW-1:0]  sm;
    logic           sm_zero;
    logic           sm_ovf;

    modport slave (
        input  in_valid, ins, cin, mode, acc_clr, out_ready,
        output in_ready, out_valid, sm, sm_zero, sm_ovf
    );

    modport master (
        output in_valid, ins, cin, mode, acc_clr, out_ready,
        input  in_ready, out_valid, sm, sm_zero, sm_ovf
    );
endinterface

// File: rtl/sum_accum_lane_sum.sv
// Combinational adder of L unsigned W-bit lanes into an OW-bit sum.
module lane_sum #(
    parameter int unsigned W  = 8,
    parameter int unsigned L  = 2,
    parameter int unsigned OW = 10
) (
    input  logic [L*W-1:0] lanes,
    output logic [OW-1:0]  sum
);
    always_comb begin
        sum = '0;
        for (int unsigned k = 0; k < L; k++) begin
            sum = sum + OW'(lanes[k*W +: W]);
        end
    end
endmodule

// File: rtl/sum_accum.sv
// Two-stage lane summer/accumulator: S1 registers two half-sums, S2 adds them
// (plus carry-in and optional accumulator) into the registered result.
module sum_accum
    import sum_accum_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 4,
    parameter int unsigned AW = 12
) (
    input  logic           clk,
    input  logic           rst,
    sum_accum_if.slave     bus
);
    localparam int unsigned HALF = N / 2;
    localparam int unsigned HW   = W + $clog2(N);
    localparam int unsigned SW   = AW + 1;

    if (AW < min_aw(W, N) || N < 2 || (N % 2) != 0) begin : g_bad_params
        $error("sum_accum: illegal W/N/AW combination");
    end

    logic [HW-1:0] h0, h1;
    logic [HW-1:0] s1_h0, s1_h1;
    logic          s1_valid, s1_cin, s1_clr;
    mode_e         s1_mode;

    logic          out_valid_q, sm_zero_q, sm_ovf_q;
    logic [AW-1:0] sm_q, acc, base;
    logic [SW-1:0] total;
    logic          s1_load, s2_load;

    lane_sum #(.W(W), .L(HALF), .OW(HW)) u_lo (
        .lanes (bus.ins[HALF*W-1:0]),
        .sum   (h0)
    );

    lane_sum #(.W(W), .L(HALF), .OW(HW)) u_hi (
        .lanes (bus.ins[N*W-1:HALF*W]),
        .sum   (h1)
    );

    // in_ready depends only on registered state and out_ready, never on in_valid
    always_comb begin
        s2_load = s1_valid && (!out_valid_q || bus.out_ready);
        s1_load = bus.in_valid && (!s1_valid || s2_load);
    end

    always_comb begin
        base  = (s1_mode == MODE_ACC && !s1_clr) ? acc : '0;
        total = SW'(base) + SW'(s1_h0) + SW'(s1_h1) + SW'(s1_cin);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_h0       <= '0;
            s1_h1       <= '0;
            s1_cin      <= 1'b0;
            s1_clr      <= 1'b0;
            s1_mode     <= MODE_SUM;
            out_valid_q <= 1'b0;
            sm_q        <= '0;
            sm_zero_q   <= 1'b0;
            sm_ovf_q    <= 1'b0;
            acc         <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_h0    <= h0;
                s1_h1    <= h1;
                s1_cin   <= bus.cin;
                s1_clr   <= bus.acc_clr;
                s1_mode  <= mode_e'(bus.mode);
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            // acc updates on the same edge as S2 so the next beat chains onto it
            if (s2_load) begin
                out_valid_q <= 1'b1;
                sm_q        <= total[AW-1:0];
                sm_zero_q   <= (total[AW-1:0] == '0);
                sm_ovf_q    <= total[AW];
                if (s1_mode == MODE_ACC) begin
                    acc <= total[AW-1:0];
                end else if (s1_clr) begin
                    acc <= '0;
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = !s1_valid || s2_load;
    assign bus.out_valid = out_valid_q;
    assign bus.sm        = sm_q;
    assign bus.sm_zero   = sm_zero_q;
    assign bus.sm_ovf    = sm_ovf_q;

endmodule

// File: tb/tb_sum_accum.sv
// Directed scoreboard bench for sum_accum (W=8, N=4, AW=12).
module tb_sum_accum;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sum_accum_if #(.W(8), .N(4), .AW(12)) bus ();

    sum_accum #(.W(8), .N(4), .AW(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int sm;
        bit z;
        bit o;
        int acc_cyc;
        bit lat;
        bit consec;
    } exp_t;

    exp_t sb[$];
    int   tests     = 0;
    int   failed    = 0;
    int   cyc       = 0;
    int   last_dcyc = -100;
    int   accepted  = 0;
    int   a0;
    exp_t e;

    always @(posedge clk) cyc = cyc + 1;

    function automatic void check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] rep(input logic [7:0] v);
        return {4{v}};
    endfunction

    // monitor: a transfer happens at the next posedge when valid && ready here
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sm", int'(bus.sm), e.sm);
                check("sm_zero", int'(bus.sm_zero), int'(e.z));
                check("sm_ovf", int'(bus.sm_ovf), int'(e.o));
                if (e.lat)    check("latency", cyc - e.acc_cyc, 2);
                if (e.consec) check("consecutive", cyc - last_dcyc, 1);
            end
            last_dcyc = cyc;
        end
    end

    // called just after a posedge; returns just after the accepting posedge
    task automatic send(input logic [31:0] ins, input logic cin, input logic mode,
                        input logic clr, input int exp_sm, input bit ez, input bit eo,
                        input bit lat = 1'b0, input bit consec = 1'b0, input bit push = 1'b1);
        int unsigned guard = 0;
        exp_t x;
        bus.in_valid = 1'b1;
        bus.ins      = ins;
        bus.cin      = cin;
        bus.mode     = mode;
        bus.acc_clr  = clr;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            accepted++;
            if (push) begin
                x.sm = exp_sm; x.z = ez; x.o = eo;
                x.acc_cyc = cyc; x.lat = lat; x.consec = consec;
                sb.push_back(x);
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", sb.size(), 0);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.ins       = '0;
        bus.cin       = 1'b0;
        bus.mode      = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_sm", int'(bus.sm), 0);
        check("rst_sm_zero", int'(bus.sm_zero), 0);
        check("rst_sm_ovf", int'(bus.sm_ovf), 0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 1);
        sync();

        // plain sums, first one with latency check
        send({8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, 1'b0, 1'b0, 11, 1'b0, 1'b0, 1'b1);
        drain(); sync();
        send(rep(8'd255), 1'b1, 1'b0, 1'b0, 1021, 1'b0, 1'b0);
        send(rep(8'd0),   1'b0, 1'b0, 1'b0, 0,    1'b1, 1'b0);
        drain(); sync();

        // chained accumulate, results on consecutive cycles
        send(rep(8'd10), 1'b0, 1'b1, 1'b1, 40,  1'b0, 1'b0);
        send(rep(8'd10), 1'b0, 1'b1, 1'b0, 80,  1'b0, 1'b0, 1'b0, 1'b1);
        send(rep(8'd10), 1'b0, 1'b1, 1'b0, 120, 1'b0, 1'b0, 1'b0, 1'b1);
        send(rep(8'd10), 1'b0, 1'b1, 1'b0, 160, 1'b0, 1'b0, 1'b0, 1'b1);
        drain(); sync();

        // build acc to 4000, then wrap
        send(rep(8'd250), 1'b0, 1'b1, 1'b1, 1000, 1'b0, 1'b0);
        send(rep(8'd250), 1'b0, 1'b1, 1'b0, 2000, 1'b0, 1'b0);
        send(rep(8'd250), 1'b0, 1'b1, 1'b0, 3000, 1'b0, 1'b0);
        send(rep(8'd250), 1'b0, 1'b1, 1'b0, 4000, 1'b0, 1'b0);
        send(rep(8'd255), 1'b0, 1'b1, 1'b0, 924,  1'b0, 1'b1);
        send(rep(8'd0),   1'b0, 1'b1, 1'b0, 924,  1'b0, 1'b0);

        // mode-0 clear zeroes acc; mode-0 without clear leaves it alone
        send(rep(8'd1), 1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b0);
        send(rep(8'd1), 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0);
        send(rep(8'd2), 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0);
        send(rep(8'd1), 1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b0);
        drain(); sync();

        // downstream stall with a 4-beat stream
        bus.out_ready = 1'b0;
        a0 = accepted;
        fork
            begin
                send(rep(8'd1), 1'b0, 1'b0, 1'b0, 4,  1'b0, 1'b0);
                send(rep(8'd2), 1'b0, 1'b0, 1'b0, 8,  1'b0, 1'b0);
                send(rep(8'd3), 1'b0, 1'b0, 1'b0, 12, 1'b0, 1'b0);
                send(rep(8'd4), 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b0);
            end
            begin
                repeat (5) @(negedge clk);
                check("stall_accepted", accepted - a0, 2);
                check("stall_in_ready", int'(bus.in_ready), 0);
                sync();
                bus.out_ready = 1'b1;
            end
        join
        drain(); sync();

        // reset with two beats in flight
        bus.out_ready = 1'b0;
        send(rep(8'd5), 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(rep(8'd5), 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        sync();
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        sync();
        send(rep(8'd1), 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
